// File: rtl/dtree_pkg.sv
// rtl/dtree_pkg.sv - shared types, field widths and node-word layout for the decision-tree classifier
package dtree_pkg;

    localparam int DEF_FEAT_W    = 8;
    localparam int DEF_N_FEAT    = 16;
    localparam int DEF_CLASS_W   = 3;
    localparam int DEF_N_NODES   = 64;
    localparam int DEF_MAX_DEPTH = 16;

    // Index fields carry one spare bit so out-of-range values can be stored and detected.
    function automatic int idx_w(input int n_feat);
        return $clog2(n_feat) + 1;
    endfunction

    function automatic int child_w(input int n_nodes);
        return $clog2(n_nodes) + 1;
    endfunction

    function automatic int node_w(input int feat_w, input int n_feat, input int class_w,
                                  input int n_nodes);
        return 1 + idx_w(n_feat) + feat_w + 2 * child_w(n_nodes) + class_w;
    endfunction

    localparam int IDX_W   = idx_w(DEF_N_FEAT);
    localparam int CHILD_W = child_w(DEF_N_NODES);
    localparam int DEPTH_W = $clog2(DEF_MAX_DEPTH + 1);
    localparam int NODE_W  = node_w(DEF_FEAT_W, DEF_N_FEAT, DEF_CLASS_W, DEF_N_NODES);

    typedef struct packed {
        logic                   is_leaf;
        logic [IDX_W-1:0]       feat_idx;
        logic [DEF_FEAT_W-1:0]  thresh;
        logic [CHILD_W-1:0]     left;
        logic [CHILD_W-1:0]     right;
        logic [DEF_CLASS_W-1:0] class_id;
    } node_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WALK = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dtree_if.sv
// rtl/dtree_if.sv - feature/result handshake, node-table config and status bundle
interface dtree_if import dtree_pkg::*; #(
    parameter int FEAT_W    = 8,
    parameter int N_FEAT    = 16,
    parameter int CLASS_W   = 3,
    parameter int N_NODES   = 64,
    parameter int MAX_DEPTH = 16
);
    localparam int NODE_W  = node_w(FEAT_W, N_FEAT, CLASS_W, N_NODES);
    localparam int ADDR_W  = $clog2(N_NODES);
    localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

    logic                     in_valid;
    logic                     in_ready;
    logic [N_FEAT*FEAT_W-1:0] in_feat;
    logic                     out_valid;
    logic                     out_ready;
    logic [CLASS_W-1:0]       out_class;
    logic [DEPTH_W-1:0]       out_depth;
    logic                     out_err;
    logic                     cfg_we;
    logic [ADDR_W-1:0]        cfg_addr;
    logic [NODE_W-1:0]        cfg_data;
    logic                     cfg_drop;
    logic                     busy;

    modport master (
        output in_valid, in_feat, out_ready, cfg_we, cfg_addr, cfg_data,
        input  in_ready, out_valid, out_class, out_depth, out_err, cfg_drop, busy
    );

    modport slave (
        input  in_valid, in_feat, out_ready, cfg_we, cfg_addr, cfg_data,
        output in_ready, out_valid, out_class, out_depth, out_err, cfg_drop, busy
    );

endinterface

// File: rtl/dtree_node_mem.sv
// rtl/dtree_node_mem.sv - node table: flop array, sync write, async read, resets to class-0 leaves
module dtree_node_mem #(
    parameter int N_NODES = 64,
    parameter int NODE_W  = 31,
    parameter int ADDR_W  = $clog2(N_NODES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [NODE_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [NODE_W-1:0] rd_data
);
    localparam logic [NODE_W-1:0] LEAF_CLASS0 = {1'b1, {(NODE_W-1){1'b0}}};

    logic [NODE_W-1:0] mem [N_NODES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NODES; i++) begin
                mem[i] <= LEAF_CLASS0;
            end
        end else if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/dtree_seq_classifier.sv
// rtl/dtree_seq_classifier.sv - walks a table-driven decision tree one node per cycle
module dtree_seq_classifier import dtree_pkg::*; #(
    parameter int FEAT_W    = 8,
    parameter int N_FEAT    = 16,
    parameter int CLASS_W   = 3,
    parameter int N_NODES   = 64,
    parameter int MAX_DEPTH = 16
) (
    input  logic    clk,
    input  logic    rst_n,
    dtree_if.slave  bus
);
    localparam int IDX_W     = idx_w(N_FEAT);
    localparam int CHILD_W   = child_w(N_NODES);
    localparam int NODE_W    = node_w(FEAT_W, N_FEAT, CLASS_W, N_NODES);
    localparam int ADDR_W    = $clog2(N_NODES);
    localparam int DEPTH_W   = $clog2(MAX_DEPTH + 1);
    localparam int RIGHT_LSB = CLASS_W;
    localparam int LEFT_LSB  = RIGHT_LSB + CHILD_W;
    localparam int THR_LSB   = LEFT_LSB + CHILD_W;
    localparam int IDX_LSB   = THR_LSB + FEAT_W;
    localparam int LEAF_BIT  = IDX_LSB + IDX_W;

    state_t                   state_q, state_d;
    logic [N_FEAT*FEAT_W-1:0] feat_q, feat_d;
    logic [NODE_W-1:0]        cur_q, cur_d;
    logic                     primed_q, primed_d;
    logic [DEPTH_W-1:0]       depth_q, depth_d;
    logic [CLASS_W-1:0]       cls_q, cls_d;
    logic [DEPTH_W-1:0]       odep_q, odep_d;
    logic                     err_q, err_d;
    logic                     drop_q;
    logic [ADDR_W-1:0]        rd_addr;
    logic [NODE_W-1:0]        rd_data;
    logic [FEAT_W-1:0]        feat_sel;

    logic                     cur_leaf;
    logic [IDX_W-1:0]         cur_idx;
    logic [FEAT_W-1:0]        cur_thr;
    logic [CHILD_W-1:0]       child;
    logic                     abort;

    assign cur_leaf = cur_q[LEAF_BIT];
    assign cur_idx  = cur_q[IDX_LSB +: IDX_W];
    assign cur_thr  = cur_q[THR_LSB +: FEAT_W];

    always_comb begin
        feat_sel = '0;
        for (int i = 0; i < N_FEAT; i++) begin
            if (cur_idx == IDX_W'(i)) feat_sel = feat_q[i*FEAT_W +: FEAT_W];
        end
    end

    assign child = (feat_sel <= cur_thr) ? cur_q[LEFT_LSB +: CHILD_W] : cur_q[RIGHT_LSB +: CHILD_W];
    assign abort = (cur_idx >= IDX_W'(N_FEAT)) || (depth_q == DEPTH_W'(MAX_DEPTH))
                || (child >= CHILD_W'(N_NODES));

    // The first WALK cycle only fetches the root; later cycles evaluate the held node and fetch its child.
    assign rd_addr = primed_q ? child[ADDR_W-1:0] : '0;

    dtree_node_mem #(
        .N_NODES(N_NODES),
        .NODE_W (NODE_W),
        .ADDR_W (ADDR_W)
    ) u_node_mem (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (bus.cfg_we && (state_q == S_IDLE)),
        .wr_addr(bus.cfg_addr),
        .wr_data(bus.cfg_data),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

    always_comb begin
        state_d  = state_q;
        feat_d   = feat_q;
        cur_d    = cur_q;
        primed_d = primed_q;
        depth_d  = depth_q;
        cls_d    = cls_q;
        odep_d   = odep_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    feat_d   = bus.in_feat;
                    depth_d  = '0;
                    primed_d = 1'b0;
                    state_d  = S_WALK;
                end
            end
            S_WALK: begin
                if (!primed_q) begin
                    cur_d    = rd_data;
                    primed_d = 1'b1;
                end else if (cur_leaf) begin
                    cls_d   = cur_q[CLASS_W-1:0];
                    odep_d  = depth_q;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (abort) begin
                    cls_d   = '0;
                    odep_d  = depth_q;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cur_d   = rd_data;
                    depth_d = depth_q + DEPTH_W'(1);
                end
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            feat_q   <= '0;
            cur_q    <= '0;
            primed_q <= 1'b0;
            depth_q  <= '0;
            cls_q    <= '0;
            odep_q   <= '0;
            err_q    <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            feat_q   <= feat_d;
            cur_q    <= cur_d;
            primed_q <= primed_d;
            depth_q  <= depth_d;
            cls_q    <= cls_d;
            odep_q   <= odep_d;
            err_q    <= err_d;
            drop_q   <= bus.cfg_we && (state_q != S_IDLE);
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.out_class = cls_q;
    assign bus.out_depth = odep_q;
    assign bus.out_err   = err_q;
    assign bus.cfg_drop  = drop_q;

endmodule

// File: tb/tb_dtree_seq_classifier.sv
// tb/tb_dtree_seq_classifier.sv - directed scoreboard bench for dtree_seq_classifier
module tb_dtree_seq_classifier;
    import dtree_pkg::*;

    localparam int FW = DEF_FEAT_W;
    localparam int NF = DEF_N_FEAT;
    localparam int VW = NF * FW;
    localparam int AW = $clog2(DEF_N_NODES);

    typedef struct {
        int cls;
        int depth;
        int err;
        int lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   nchk = 0;
    int   nerr = 0;
    exp_t sb[$];

    dtree_if #(
        .FEAT_W(DEF_FEAT_W), .N_FEAT(DEF_N_FEAT), .CLASS_W(DEF_CLASS_W),
        .N_NODES(DEF_N_NODES), .MAX_DEPTH(DEF_MAX_DEPTH)
    ) bus ();

    dtree_seq_classifier #(
        .FEAT_W(DEF_FEAT_W), .N_FEAT(DEF_N_FEAT), .CLASS_W(DEF_CLASS_W),
        .N_NODES(DEF_N_NODES), .MAX_DEPTH(DEF_MAX_DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [NODE_W-1:0] mk(input int leaf, input int idx, input int thr,
                                             input int l, input int r, input int cls);
        node_t n;
        n.is_leaf  = leaf[0];
        n.feat_idx = IDX_W'(idx);
        n.thresh   = FW'(thr);
        n.left     = CHILD_W'(l);
        n.right    = CHILD_W'(r);
        n.class_id = DEF_CLASS_W'(cls);
        return n;
    endfunction

    function automatic logic [VW-1:0] fv(input int f3, input int f7);
        logic [VW-1:0] v;
        v = '0;
        v[3*FW +: FW] = FW'(f3);
        v[7*FW +: FW] = FW'(f7);
        return v;
    endfunction

    task automatic write_node(input int addr, input logic [NODE_W-1:0] data);
        @(negedge clk);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = AW'(addr);
        bus.cfg_data = data;
        @(negedge clk);
        bus.cfg_we   = 1'b0;
    endtask

    // cfg_mode: 0 none, 1 write in the accept cycle, 2 write during the walk (must be dropped)
    task automatic run_vec(input logic [VW-1:0] f, input int ecls, input int edep, input int eerr,
                           input int elat, input int hold, input int cfg_mode, input int caddr,
                           input logic [NODE_W-1:0] cdata);
        exp_t e;
        int   t0;
        e = '{ecls, edep, eerr, elat};
        sb.push_back(e);
        @(negedge clk);
        check("in_ready_before_accept", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_feat  = f;
        if (cfg_mode == 1) begin
            bus.cfg_we   = 1'b1;
            bus.cfg_addr = AW'(caddr);
            bus.cfg_data = cdata;
        end
        @(posedge clk);
        #1 t0 = cyc;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.cfg_we   = 1'b0;
        if (cfg_mode == 2) begin
            bus.cfg_we   = 1'b1;
            bus.cfg_addr = AW'(caddr);
            bus.cfg_data = cdata;
            @(negedge clk);
            bus.cfg_we = 1'b0;
            check("cfg_drop_pulse", bus.cfg_drop, 1);
        end
        for (int i = 0; i < 40 && bus.out_valid !== 1'b1; i++) @(negedge clk);
        e = sb.pop_front();
        if (bus.out_valid !== 1'b1) begin
            check("out_valid_timeout", bus.out_valid, 1);
            return;
        end
        check("latency", cyc - t0, e.lat);
        check("class", bus.out_class, e.cls);
        check("depth", bus.out_depth, e.depth);
        check("err", bus.out_err, e.err);
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = 1'b1;
            bus.in_feat  = ~f;
            @(negedge clk);
            check("hold_valid", bus.out_valid, 1);
            check("hold_class", bus.out_class, e.cls);
            check("hold_depth", bus.out_depth, e.depth);
            check("hold_err", bus.out_err, e.err);
            check("hold_in_ready", bus.in_ready, 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("post_handshake_busy", bus.busy, 0);
        check("post_handshake_in_ready", bus.in_ready, 1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_feat   = '0;
        bus.out_ready = 1'b0;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_data  = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_out_class", bus.out_class, 0);
        check("rst_out_depth", bus.out_depth, 0);
        check("rst_out_err", bus.out_err, 0);
        check("rst_cfg_drop", bus.cfg_drop, 0);
        rst_n = 1'b1;

        // root-only leaf
        write_node(0, mk(1, 0, 0, 0, 0, 5));
        run_vec(fv(0, 0), 5, 0, 0, 2, 0, 0, 0, '0);

        // depth-2 table
        write_node(0, mk(0, 3, 100, 1, 2, 0));
        write_node(1, mk(1, 0, 0, 0, 0, 1));
        write_node(2, mk(0, 7, 20, 3, 4, 0));
        write_node(3, mk(1, 0, 0, 0, 0, 2));
        write_node(4, mk(1, 0, 0, 0, 0, 6));
        run_vec(fv(101, 20), 2, 2, 0, 4, 0, 0, 0, '0);
        run_vec(fv(100, 0),  1, 1, 0, 3, 0, 0, 0, '0);
        run_vec(fv(255, 21), 6, 2, 0, 4, 0, 0, 0, '0);
        run_vec(fv(0, 255),  1, 1, 0, 3, 0, 0, 0, '0);

        // backpressure with a competing in_valid
        run_vec(fv(101, 20), 2, 2, 0, 4, 5, 0, 0, '0);

        // write during WALK is dropped; table contents unchanged afterwards
        run_vec(fv(255, 21), 6, 2, 0, 4, 0, 2, 1, mk(1, 0, 0, 0, 0, 7));
        run_vec(fv(100, 0),  1, 1, 0, 3, 0, 0, 0, '0);

        // bad feature index
        write_node(0, mk(0, NF, 0, 1, 2, 0));
        run_vec(fv(0, 0), 0, 0, 1, 2, 0, 0, 0, '0);

        // same-cycle write and accept: the walk sees the new root
        run_vec(fv(0, 0), 3, 0, 0, 2, 0, 1, 0, mk(1, 0, 0, 0, 0, 3));

        // child index beyond the table
        write_node(0, mk(0, 0, 255, DEF_N_NODES, 1, 0));
        run_vec(fv(0, 0), 0, 0, 1, 2, 0, 0, 0, '0);

        // self-loop hits the depth limit
        write_node(0, mk(0, 0, 0, 0, 0, 4));
        run_vec(fv(0, 0), 0, DEF_MAX_DEPTH, 1, DEF_MAX_DEPTH + 2, 0, 0, 0, '0);

        // reset mid-walk
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_feat  = fv(0, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("midwalk_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", bus.out_valid, 0);
        check("async_rst_busy", bus.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", bus.in_ready, 1);
        check("post_rst_out_valid", bus.out_valid, 0);
        run_vec(fv(0, 0), 0, 0, 0, 2, 0, 0, 0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/dtree_seq_classifier.md
DTREE_SEQ_CLASSIFIER -- requirements
Module: dtree_seq_classifier

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- FEAT_W, 8, feature width
- N_FEAT, 16, features per vector
- CLASS_W, 3, class label width
- N_NODES, 64, node-table entries
- MAX_DEPTH, 16, walk-step limit
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, sole clock
- rst_n, in, 1, asynchronous active-low reset
- in_valid, in, 1, feature vector valid
- in_ready, out, 1, block can accept a vector
- in_feat, in, N_FEAT*FEAT_W, feature vector; feature i is at bits [i*FEAT_W +: FEAT_W]
- out_valid, out, 1, result valid
- out_ready, in, 1, consumer accepts the result
- out_class, out, CLASS_W, predicted class
- out_depth, out, clog2(MAX_DEPTH+1), number of internal nodes traversed
- out_err, out, 1, walk aborted
- cfg_we, in, 1, node-table write strobe
- cfg_addr, in, clog2(N_NODES), node index
- cfg_data, in, NODE_W, node word
- cfg_drop, out, 1, one-cycle pulse when a write is rejected
- busy, out, 1, FSM is not in IDLE

Function
REQ-003 The node word SHALL contain {is_leaf, feat_idx, thresh[FEAT_W], left, right, class[CLASS_W]}, packed MSB to LSB as defined in the package.
REQ-004 The FSM SHALL have three states, IDLE, WALK and DONE, with in_ready=1 only in IDLE.
REQ-005 When in_valid&&in_ready holds in IDLE, the block SHALL register in_feat, set node=0 and depth=0, and enter WALK.
REQ-006 Each WALK cycle SHALL evaluate exactly one node: if is_leaf, latch class and depth and go to DONE.
REQ-007 Otherwise the next node SHALL be left if feat[feat_idx] <= thresh (unsigned compare, so equality goes left), else right, and depth SHALL increment.
REQ-008 The block SHALL abort to DONE with out_err=1 and out_class=0 when feat_idx >= N_FEAT, when the selected child >= N_NODES, or when depth reaches MAX_DEPTH without reaching a leaf.
REQ-009 Latency: for an accept at edge T and a leaf at depth d, out_valid SHALL rise at edge T+d+2.
REQ-010 In DONE, out_valid=1 and out_class, out_depth and out_err SHALL stay stable until out_ready=1; on that handshake edge the FSM SHALL return to IDLE, with no overlap with a new accept.
REQ-011 cfg_we SHALL write the node table only in IDLE.
REQ-012 A cfg_we in WALK or DONE SHALL be dropped and cause cfg_drop to pulse on the next cycle, with the in-flight result unaffected.
REQ-013 If cfg_we and an in_valid accept occur in the same IDLE cycle, the write SHALL complete and the walk SHALL see the new node value.
REQ-014 busy SHALL equal (state != IDLE).

Reset
REQ-015 Asserting rst_n low SHALL asynchronously force: state=IDLE, out_valid=0, out_class=0, out_depth=0, out_err=0, cfg_drop=0, busy=0.
REQ-016 Reset SHALL set every node-table entry to a leaf with class 0.
REQ-017 Reset asserted mid-WALK or mid-DONE SHALL discard the in-flight vector, and in_ready SHALL be 1 on the first cycle after release.

Structure
REQ-018 Package dtree_pkg SHALL hold the node struct, the field-width localparams derived from the parameters, the NODE_W calculation, and the FSM state enum.
REQ-019 The node table SHALL be a separate sub-module, dtree_node_mem: flop array, one synchronous write port, one asynchronous read port, and the reset behaviour of REQ-016.

Verification
REQ-020 Root-only leaf: node0 is a leaf with class 5; accept at edge T -> out_valid at T+2 with class=5, depth=0, err=0.
REQ-021 Depth-2 walk, with table:
- node0: feat3, thresh 100, left=1, right=2
- node1: leaf, class 1
- node2: feat7, thresh 20, left=3, right=4
- node3: leaf, class 2
- node4: leaf, class 6
Required responses:
- feat3=101, feat7=20 -> class 2, depth 2, out_valid at T+4
- feat3=100 -> class 1, depth 1
- feat3=255, feat7=21 -> class 6
REQ-022 Backpressure: hold out_ready=0 for 5 cycles after out_valid -> class, depth and err stay stable, in_ready=0, and a second in_valid is not accepted until the handshake.
REQ-023 Self-loop: node0 internal with left=right=0 and MAX_DEPTH=16 -> out_err=1, class=0, depth=16, out_valid at T+18.
REQ-024 Bad index: node0 has feat_idx=N_FEAT -> err=1 at T+2. Separately, cfg_we during WALK -> cfg_drop pulses and the table readback is unchanged.
REQ-025 Reset mid-WALK -> out_valid=0 and in_ready=1 after release, and node0 evaluates as a leaf with class 0.
